// File: rtl/cov_acc_pkg.sv
// Shared types and sizing helpers for the coverage bitmap accumulator.
package cov_acc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int WORD_W_DEF = 64;

    function automatic int depth_f(input int idx_w, input int word_w);
        return (1 << idx_w) / word_w;
    endfunction

    function automatic int off_w_f(input int word_w);
        return $clog2(word_w);
    endfunction

endpackage

// File: rtl/cov_bitmap_ram.sv
// Seen-bitmap storage: one registered read port, one write port.
// A read and write to the same word in one cycle returns the old contents.
module cov_bitmap_ram #(
    parameter int DEPTH  = 64,
    parameter int WORD_W = 64,
    parameter int AW     = 6
) (
    input  logic              clock,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_q;

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_addr];
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/cov_bitmap_accumulator.sv
// Counts unique coverage-point hits per round using a swept seen-bitmap.
// Optional COV_LAST_NEW_TS_EN adds a cycle counter and last_new_cycle output.
module cov_bitmap_accumulator
    import cov_acc_pkg::*;
#(
    parameter int IDX_W  = 12,
    parameter int WORD_W = WORD_W_DEF,
    parameter int SUM_W  = 30
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hit_valid,
    input  logic [IDX_W-1:0] hit_idx,
    output logic             hit_ready,
    input  logic             clr_req,
    output logic             clr_done,
    output logic [SUM_W-1:0] cov_sum,
    output logic             new_cov
`ifdef COV_LAST_NEW_TS_EN
    ,
    output logic [31:0]      last_new_cycle
`endif
);

    localparam int DEPTH = depth_f(IDX_W, WORD_W);
    localparam int OFF_W = off_w_f(WORD_W);
    localparam int AW    = IDX_W - OFF_W;

    state_t            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic [AW-1:0]     fwd_word_q, fwd_word_d;
    logic [WORD_W-1:0] fwd_data_q, fwd_data_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              new_cov_q, new_cov_d;
    logic              clr_done_q, clr_done_d;

    logic [WORD_W-1:0] rd_data, cur_word, new_word, wr_data;
    logic [AW-1:0]     s1_word, wr_addr;
    logic [OFF_W-1:0]  s1_bit;
    logic              accept, clr_go, s1_commit, is_new, wr_en;

    cov_bitmap_ram #(
        .DEPTH (DEPTH),
        .WORD_W(WORD_W),
        .AW    (AW)
    ) u_ram (
        .clock  (clock),
        .rd_addr(hit_idx[IDX_W-1:OFF_W]),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    assign hit_ready = (state_q == IDLE) && !clr_req;
    assign accept    = hit_valid && hit_ready;
    assign clr_go    = (state_q == IDLE) && clr_req;

    assign s1_word   = s1_idx_q[IDX_W-1:OFF_W];
    assign s1_bit    = s1_idx_q[OFF_W-1:0];
    // The RAM returns pre-write data, so the previous cycle's write is bypassed here.
    assign cur_word  = (fwd_valid_q && fwd_word_q == s1_word) ? fwd_data_q : rd_data;
    assign is_new    = !cur_word[s1_bit];
    assign new_word  = cur_word | ({{(WORD_W-1){1'b0}}, 1'b1} << s1_bit);
    assign s1_commit = s1_valid_q && (state_q == IDLE) && !clr_go;

    always_comb begin
        wr_en   = s1_commit;
        wr_addr = s1_word;
        wr_data = new_word;
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = ptr_q;
            wr_data = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        s1_valid_d  = accept;
        s1_idx_d    = accept ? hit_idx : s1_idx_q;
        fwd_valid_d = s1_commit;
        fwd_word_d  = s1_word;
        fwd_data_d  = new_word;
        sum_d       = sum_q;
        new_cov_d   = 1'b0;
        clr_done_d  = 1'b0;

        if (s1_commit && is_new) begin
            new_cov_d = 1'b1;
            if (sum_q != {SUM_W{1'b1}}) sum_d = sum_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    ptr_d     = '0;
                    sum_d     = '0;
                    new_cov_d = 1'b0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == AW'(DEPTH - 1)) begin
                    ptr_d      = '0;
                    clr_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= CLEAR;
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            fwd_valid_q <= 1'b0;
            fwd_word_q  <= '0;
            fwd_data_q  <= '0;
            sum_q       <= '0;
            new_cov_q   <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_word_q  <= fwd_word_d;
            fwd_data_q  <= fwd_data_d;
            sum_q       <= sum_d;
            new_cov_q   <= new_cov_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign cov_sum  = sum_q;
    assign new_cov  = new_cov_q;
    assign clr_done = clr_done_q;

`ifdef COV_LAST_NEW_TS_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] last_q, last_d;

    // Loaded one edge early so it is visible in the same cycle new_cov is high.
    always_comb begin
        cyc_d  = cyc_q + 32'd1;
        last_d = last_q;
        if (s1_commit && is_new) last_d = cyc_q;
        if (clr_go)              last_d = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc_q  <= '0;
            last_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            last_q <= last_d;
        end
    end

    assign last_new_cycle = last_q;
`endif

endmodule
